mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch (F) and data (D) share one memory.
// D has priority; F is forced through after STARVE_LIMIT D grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic        d_req,
    input  logic [31:0] f_addr,
    input  logic [31:0] d_addr,
    input  logic        d_write,
    input  logic        d_signed,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        f_gnt,
    output logic        d_gnt,
    output logic        f_done,
    output logic        d_done,
    output logic [31:0] f_rdata,
    output logic [31:0] d_rdata,
    output logic        f_fault,
    output logic        d_fault,
    output logic        mem_en,
    output logic        mem_write,
    output logic        mem_signed,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy,
    input  logic        mem_fault
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam logic [2:0] SLIM  = 3'(STARVE_LIMIT);
    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        win_q, win_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        signed_q, signed_d;
    logic [1:0]  size_q, size_d;
    logic [2:0]  starve_q, starve_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        fault_q, fault_d;
    logic [31:0] f_rdata_q, f_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic any_req;
    logic pick_d;

    // Arbitration: D wins unless F is waiting and has been starved out.
    always_comb begin
        any_req = f_req | d_req;
        pick_d  = d_req & ~(f_req & (starve_q == SLIM));
    end

    // Next-state, command capture, completion/timeout and grant pulses.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        signed_d  = signed_q;
        size_d    = size_q;
        starve_d  = starve_q;
        tmo_d     = tmo_q;
        fault_d   = fault_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        f_gnt     = 1'b0;
        d_gnt     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req && !reset) begin
                    state_d = BUSY;
                    win_d   = pick_d;
                    tmo_d   = 8'd0;
                    f_gnt   = ~pick_d;
                    d_gnt   = pick_d;
                    if (pick_d) begin
                        addr_d   = d_addr;
                        wdata_d  = d_wdata;
                        write_d  = d_write;
                        signed_d = d_signed;
                        size_d   = d_size;
                        if (f_req && starve_q != SLIM) begin
                            starve_d = starve_q + 3'd1;
                        end
                    end else begin
                        addr_d   = f_addr;
                        wdata_d  = 32'd0;
                        write_d  = 1'b0;
                        signed_d = 1'b0;
                        size_d   = 2'b10;
                        starve_d = 3'd0;
                    end
                end
            end
            BUSY: begin
                if (!mem_busy) begin
                    state_d = DONE;
                    fault_d = mem_fault;
                    if (win_q) d_rdata_d = mem_rdata;
                    else       f_rdata_d = mem_rdata;
                end else if (tmo_q == TLAST) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    if (win_q) d_rdata_d = 32'd0;
                    else       f_rdata_d = 32'd0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory command and per-port results decoded from registered state.
    always_comb begin
        mem_en     = (state_q == BUSY);
        mem_write  = mem_en & write_q;
        mem_signed = signed_q;
        mem_size   = size_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        f_done     = (state_q == DONE) & ~win_q;
        d_done     = (state_q == DONE) & win_q;
        f_fault    = f_done & fault_q;
        d_fault    = d_done & fault_q;
        f_rdata    = f_rdata_q;
        d_rdata    = d_rdata_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            win_q     <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            write_q   <= 1'b0;
            signed_q  <= 1'b0;
            size_q    <= 2'b00;
            starve_q  <= 3'd0;
            tmo_q     <= 8'd0;
            fault_q   <= 1'b0;
            f_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            signed_q  <= signed_d;
            size_q    <= size_d;
            starve_q  <= starve_d;
            tmo_q     <= tmo_d;
            fault_q   <= fault_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random transactions
// checked against a transaction-level arbitration/memory model.
module tb_mem_arbiter;

    localparam int SL  = 4;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, d_req;
    logic [31:0] f_addr, d_addr;
    logic        d_write, d_signed;
    logic [1:0]  d_size;
    logic [31:0] d_wdata;
    logic        f_gnt, d_gnt, f_done, d_done;
    logic [31:0] f_rdata, d_rdata;
    logic        f_fault, d_fault;
    logic        mem_en, mem_write, mem_signed;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_busy, mem_fault;

    int n_chk = 0;
    int n_err = 0;

    int          starve = 0;
    logic [31:0] exp_frd = 32'd0;
    logic [31:0] exp_drd = 32'd0;

    mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .d_req(d_req),
        .f_addr(f_addr), .d_addr(d_addr),
        .d_write(d_write), .d_signed(d_signed),
        .d_size(d_size), .d_wdata(d_wdata),
        .f_gnt(f_gnt), .d_gnt(d_gnt),
        .f_done(f_done), .d_done(d_done),
        .f_rdata(f_rdata), .d_rdata(d_rdata),
        .f_fault(f_fault), .d_fault(d_fault),
        .mem_en(mem_en), .mem_write(mem_write),
        .mem_signed(mem_signed), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request cycle in IDLE; if granted, run the memory for lat busy
    // cycles (lat >= TMO means the memory never answers), then DONE.
    task automatic txn(input bit fr, input bit dr,
                       input logic [31:0] fa, input logic [31:0] da,
                       input logic [31:0] dw, input bit dwr,
                       input bit dsg, input logic [1:0] dsz,
                       input int lat, input logic [31:0] rd,
                       input bit flt, input bit drop);
        bit          any, wd, ewr, esg, ef;
        logic [31:0] ea, ew, er;
        logic [1:0]  esz;
        int          nb;
        f_req = fr; d_req = dr;
        f_addr = fa; d_addr = da; d_wdata = dw;
        d_write = dwr; d_signed = dsg; d_size = dsz;
        mem_busy = 1'b1; mem_fault = 1'b0; mem_rdata = $urandom;
        #1;
        chk("idle_mem_en", 32'(mem_en), 32'd0);
        chk("idle_f_done", 32'(f_done), 32'd0);
        chk("idle_d_done", 32'(d_done), 32'd0);
        chk("idle_f_fault", 32'(f_fault), 32'd0);
        chk("idle_d_fault", 32'(d_fault), 32'd0);
        chk("idle_f_rdata", f_rdata, exp_frd);
        chk("idle_d_rdata", d_rdata, exp_drd);
        any = fr | dr;
        wd  = dr && !(fr && starve == SL);
        chk("f_gnt", 32'(f_gnt), 32'(any && !wd));
        chk("d_gnt", 32'(d_gnt), 32'(any && wd));
        if (!any) begin
            @(negedge clk);
            return;
        end
        if (!wd) starve = 0;
        else if (fr && starve < SL) starve++;
        ea  = wd ? da : fa;
        ew  = wd ? dw : 32'd0;
        ewr = wd ? dwr : 1'b0;
        esg = wd ? dsg : 1'b0;
        esz = wd ? dsz : 2'b10;
        nb  = (lat < TMO) ? lat + 1 : TMO;
        for (int c = 0; c < nb; c++) begin
            @(negedge clk);
            if (drop) begin
                f_req = 1'b0; d_req = 1'b0;
            end
            f_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            d_write = 1'($urandom); d_signed = 1'($urandom);
            d_size = 2'($urandom);
            mem_busy  = (c < lat);
            mem_rdata = (c < lat) ? $urandom : rd;
            mem_fault = (c < lat) ? 1'($urandom) : flt;
            #1;
            chk("busy_mem_en", 32'(mem_en), 32'd1);
            chk("busy_addr", mem_addr, ea);
            chk("busy_wdata", mem_wdata, ew);
            chk("busy_write", 32'(mem_write), 32'(ewr));
            chk("busy_signed", 32'(mem_signed), 32'(esg));
            chk("busy_size", 32'(mem_size), 32'(esz));
            chk("busy_gnt", 32'({f_gnt, d_gnt}), 32'd0);
            chk("busy_done", 32'({f_done, d_done}), 32'd0);
        end
        er = (lat < TMO) ? rd : 32'd0;
        ef = (lat < TMO) ? flt : 1'b1;
        if (wd) exp_drd = er;
        else    exp_frd = er;
        @(negedge clk);
        mem_busy = 1'b1; mem_rdata = $urandom; mem_fault = 1'($urandom);
        #1;
        chk("done_mem_en", 32'(mem_en), 32'd0);
        chk("done_gnt", 32'({f_gnt, d_gnt}), 32'd0);
        chk("f_done", 32'(f_done), 32'(!wd));
        chk("d_done", 32'(d_done), 32'(wd));
        chk("f_fault", 32'(f_fault), 32'(!wd && ef));
        chk("d_fault", 32'(d_fault), 32'(wd && ef));
        chk("f_rdata", f_rdata, exp_frd);
        chk("d_rdata", d_rdata, exp_drd);
        @(negedge clk);
    endtask

    // Data read aborted by reset on its second BUSY cycle.
    task automatic reset_mid_busy();
        f_req = 1'b0; d_req = 1'b1; d_addr = $urandom;
        d_write = 1'b0; mem_busy = 1'b1;
        #1;
        chk("rst_d_gnt", 32'(d_gnt), 32'd1);
        @(negedge clk); #1;
        chk("rst_busy1_en", 32'(mem_en), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_busy2_en", 32'(mem_en), 32'd1);
        @(negedge clk); #1;
        chk("rst_after_en", 32'(mem_en), 32'd0);
        chk("rst_after_done", 32'({f_done, d_done}), 32'd0);
        chk("rst_req_ignored", 32'({f_gnt, d_gnt}), 32'd0);
        starve  = 0;
        exp_frd = 32'd0;
        exp_drd = 32'd0;
        reset = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        f_req = 1'b1; d_req = 1'b1;
        f_addr = 32'h40; d_addr = 32'h80; d_wdata = 32'h0;
        d_write = 1'b1; d_signed = 1'b0; d_size = 2'b01;
        mem_rdata = 32'h0; mem_busy = 1'b0; mem_fault = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", 32'({f_gnt, d_gnt}), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_done", 32'({f_done, d_done}), 32'd0);
        chk("rst_fault", 32'({f_fault, d_fault}), 32'd0);
        chk("rst_f_rdata", f_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        // both requesting at release: D first, then F at the next IDLE
        txn(1, 1, 32'h200, 32'h300, 32'h11, 0, 1, 2'b01,
            0, 32'h1234_5678, 0, 0);
        txn(1, 0, 32'h204, 32'h0, 32'h0, 0, 0, 2'b00,
            0, 32'h0BAD_F00D, 0, 0);
        // single fetch, two busy cycles
        txn(1, 0, 32'h100, 32'h0, 32'h0, 0, 0, 2'b00,
            2, 32'hDEAD_BEEF, 0, 0);
        // byte store that faults, requester drops after grant
        txn(0, 1, 32'h0, 32'h804, 32'hA5A5_5A5A, 1, 0, 2'b00,
            1, 32'h5555_AAAA, 1, 1);
        // memory never answers
        txn(0, 1, 32'h0, 32'h900, 32'h0, 0, 1, 2'b10,
            20, 32'hFFFF_FFFF, 0, 0);
        // starvation: four D grants then F
        for (int i = 0; i < 5; i++)
            txn(1, 1, 32'h1000 + 32'(i), 32'h2000 + 32'(i), $urandom,
                0, 0, 2'b10, i % 3, $urandom, 0, 0);
        for (int i = 0; i < 2; i++)
            txn(1, 1, 32'h3000, 32'h4000, $urandom, 1, 0, 2'b01,
                1, $urandom, 0, 0);
        reset_mid_busy();
        for (int i = 0; i < 5; i++)
            txn(1, 1, 32'h5000 + 32'(i), 32'h6000, $urandom,
                0, 1, 2'b00, 0, $urandom, 0, 0);
        for (int i = 0; i < 120; i++)
            txn(1'($urandom), 1'($urandom), $urandom, $urandom,
                $urandom, 1'($urandom), 1'($urandom), 2'($urandom),
                int'($urandom_range(0, 10)), $urandom,
                1'($urandom), 1'($urandom));
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
